// File: rtl/lsu_pkg.sv
// Shared types for the load/store memory stage: FSM states, RV32I funct3
// access encodings and fault cause codes.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_ILLEGAL  = 2'b10,
    CAUSE_TIMEOUT  = 2'b11
  } cause_e;

endpackage

// File: rtl/lsu_if.sv
// Data-memory port: req/gnt request phase followed by an rvalid data phase.
interface lsu_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, be, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, be, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store-data replication and access
// checks on the request side; lane extraction and extension on the load side.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        is_store,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misalign,
  output logic        illegal,
  output logic [31:0] load_ext
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    be       = '0;
    wdata    = '0;
    misalign = 1'b0;
    illegal  = 1'b0;
    case (funct3)
      F3_B: begin
        be = 4'b0001 << addr_lo;
        if (is_store) wdata = {4{store_data[7:0]}};
      end
      F3_H: begin
        be       = 4'b0011 << addr_lo;
        misalign = addr_lo[0];
        if (is_store) wdata = {2{store_data[15:0]}};
      end
      F3_W: begin
        be       = 4'b1111;
        misalign = |addr_lo;
        if (is_store) wdata = store_data;
      end
      F3_BU: begin
        be      = 4'b0001 << addr_lo;
        illegal = is_store;
      end
      F3_HU: begin
        be       = 4'b0011 << addr_lo;
        misalign = addr_lo[0];
        illegal  = is_store;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign lane_b = rdata[{ld_addr_lo, 3'b000} +: 8];
  assign lane_h = rdata[{ld_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    case (ld_funct3)
      F3_B:    load_ext = {{24{lane_b[7]}}, lane_b};
      F3_H:    load_ext = {{16{lane_h[15]}}, lane_h};
      F3_BU:   load_ext = {24'h0, lane_b};
      F3_HU:   load_ext = {16'h0, lane_h};
      default: load_ext = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_memstage.sv
// Memory stage: runs one load/store over the req/gnt/rvalid port while
// stalling the core, with access checks and a bus timeout.
module lsu_memstage
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        ld_valid,
  output logic        fault,
  output logic [1:0]  fault_cause,
  lsu_if.master       dmem
);

  localparam int unsigned CW = $clog2(TIMEOUT);

  state_e        state;
  logic [CW-1:0] cnt;
  logic [2:0]    lat_f3;
  logic [1:0]    lat_lo;
  logic          lat_we;
  logic [31:0]   lat_addr;
  logic [31:0]   lat_wdata;
  logic [3:0]    lat_be;
  logic          to_fault;

  logic [3:0]    be_c;
  logic [31:0]   wdata_c;
  logic [31:0]   ld_ext;
  logic          misalign;
  logic          illegal_f3;

  logic          idle;
  logic          any_op;
  logic          both_op;
  logic          bad_op;
  logic          good_op;
  logic          timeout;

  lsu_align u_align (
    .funct3     (funct3),
    .is_store   (mem_write),
    .addr_lo    (alu_result[1:0]),
    .store_data (store_data),
    .ld_funct3  (lat_f3),
    .ld_addr_lo (lat_lo),
    .rdata      (dmem.rdata),
    .be         (be_c),
    .wdata      (wdata_c),
    .misalign   (misalign),
    .illegal    (illegal_f3),
    .load_ext   (ld_ext)
  );

  // The IDLE decode is combinational, so gate it with rst_n to keep stall and
  // fault low for the whole time reset is held.
  assign idle    = (state == IDLE) && rst_n;
  assign any_op  = mem_read | mem_write;
  assign both_op = mem_read & mem_write;
  assign bad_op  = any_op && (both_op || illegal_f3 || misalign);
  assign good_op = (mem_read ^ mem_write) && !illegal_f3 && !misalign;
  assign timeout = (cnt == CW'(TIMEOUT - 1));

  assign stall = (state == REQ) || (state == RESP) || (idle && good_op);
  assign fault = (idle && bad_op) || to_fault;

  always_comb begin
    fault_cause = CAUSE_NONE;
    if (idle && bad_op)
      fault_cause = (both_op || illegal_f3) ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
    else if (to_fault)
      fault_cause = CAUSE_TIMEOUT;
  end

  assign dmem.req   = (state == REQ);
  assign dmem.we    = lat_we;
  assign dmem.addr  = lat_addr;
  assign dmem.wdata = lat_wdata;
  assign dmem.be    = lat_be;

  // NOTE: the request fields and load_data are architecturally visible after
  // reset, so they are flops with a reset value rather than reset-free storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_f3    <= '0;
      lat_lo    <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      to_fault  <= 1'b0;
      ld_valid  <= 1'b0;
      load_data <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below sees
      // the pre-edge values of state and cnt.
      ld_valid <= 1'b0;
      to_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (good_op) begin
            state     <= REQ;
            cnt       <= '0;
            lat_f3    <= funct3;
            lat_lo    <= alu_result[1:0];
            lat_we    <= mem_write;
            lat_addr  <= {alu_result[31:2], 2'b00};
            lat_wdata <= wdata_c;
            lat_be    <= be_c;
          end
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          if (dmem.gnt && lat_we) begin
            state <= DONE;
          end else if (timeout) begin
            state     <= DONE;
            to_fault  <= 1'b1;
            load_data <= '0;
          end else if (dmem.gnt) begin
            state <= RESP;
          end
        end
        RESP: begin
          cnt <= cnt + 1'b1;
          if (dmem.rvalid) begin
            state     <= DONE;
            load_data <= ld_ext;
            ld_valid  <= 1'b1;
          end else if (timeout) begin
            state     <= DONE;
            to_fault  <= 1'b1;
            load_data <= '0;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_memstage.sv
// Self-checking bench for lsu_memstage: directed vector table, randomized
// accesses against a behavioural model, and reset / late-rvalid sequences.
module tb_lsu_memstage;

  localparam int TIMEOUT = 16;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    int          gd;      // grant on the gd-th request cycle, 0 = never
    int          k;       // rvalid k cycles after grant, 0 = never
    logic [31:0] rdata;
    int          e_stall;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [1:0]  e_cause;
    logic        e_ldv;
    logic [31:0] e_ld;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic        stall;
  logic [31:0] load_data;
  logic        ld_valid;
  logic        fault;
  logic [1:0]  fault_cause;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_ld;

  lsu_if dif ();

  lsu_memstage #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .funct3      (funct3),
    .alu_result  (alu_result),
    .store_data  (store_data),
    .stall       (stall),
    .load_data   (load_data),
    .ld_valid    (ld_valid),
    .fault       (fault),
    .fault_cause (fault_cause),
    .dmem        (dif)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_n) assert (!(dif.req && dif.gnt && dif.rvalid))
      else $error("gnt and rvalid together in a request cycle");

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] d, input int gd,
                               input int k, input logic [31:0] rdata, input int es,
                               input logic [3:0] ebe, input logic [31:0] ewd,
                               input logic [1:0] ec, input logic eldv, input logic [31:0] eld);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.data = d; v.gd = gd; v.k = k;
    v.rdata = rdata; v.e_stall = es; v.e_be = ebe; v.e_wdata = ewd; v.e_cause = ec;
    v.e_ldv = eldv; v.e_ld = eld;
    return v;
  endfunction

  // Reference model: derives expectations from access size, alignment and
  // response timing using plain arithmetic.
  function automatic vec_t model(input vec_t v, input logic [31:0] last);
    vec_t        r;
    int          size;
    int          lo;
    int          n;
    bit          legal;
    logic [63:0] mask;
    logic [31:0] val;
    r = v;
    size  = (v.f3[1:0] == 2'd0) ? 1 : (v.f3[1:0] == 2'd1) ? 2 : 4;
    legal = v.wr ? (v.f3 inside {3'd0, 3'd1, 3'd2})
                 : (v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    lo = int'(v.addr[1:0]);
    r.e_stall = 0; r.e_be = '0; r.e_wdata = '0; r.e_cause = 2'b00; r.e_ldv = 1'b0; r.e_ld = last;
    if (!v.rd && !v.wr) return r;
    if ((v.rd && v.wr) || !legal) begin r.e_cause = 2'b10; return r; end
    if (lo % size != 0) begin r.e_cause = 2'b01; return r; end
    r.e_be = 4'(((1 << size) - 1) << lo);
    if (v.wr)
      for (int i = 0; i < 4; i++) r.e_wdata[8*i +: 8] = v.data[8*(i % size) +: 8];
    n = (v.gd == 0 || (v.rd && v.k == 0)) ? 999 : v.gd + (v.rd ? v.k : 0);
    if (n > TIMEOUT) begin
      r.e_stall = TIMEOUT + 1; r.e_cause = 2'b11; r.e_ld = '0;
      return r;
    end
    r.e_stall = 1 + n;
    if (v.rd) begin
      mask = (64'd1 << (8 * size)) - 64'd1;
      val  = (v.rdata >> (8 * lo)) & mask[31:0];
      if (!v.f3[2] && size < 4 && val[8*size-1]) val = val | ~mask[31:0];
      r.e_ldv = 1'b1;
      r.e_ld  = val;
    end
    return r;
  endfunction

  // Presents one instruction, plays the memory side and compares the outcome.
  task automatic run_op(input string tag, input vec_t v);
    int          stall_n = 0, fault_n = 0, ldv_n = 0, reqn = 0, since = 0, cyc = 0;
    bit          granted = 0, waiting = 0, done = 0, req_seen = 0, exp_req;
    logic [1:0]  cause = 2'b00;
    logic [31:0] ld_pulse = '0, g_addr = '0, g_wdata = '0;
    logic [3:0]  g_be = '0;
    logic        g_we = 1'b0;
    @(posedge clk); #1;
    mem_read = v.rd; mem_write = v.wr; funct3 = v.f3;
    alu_result = v.addr; store_data = v.data;
    while (!done && cyc < 40) begin
      if (cyc > 0) begin @(posedge clk); #1; end
      dif.gnt = 1'b0; dif.rvalid = 1'b0; dif.rdata = $urandom;
      if (dif.req) begin
        reqn++;
        if (v.gd != 0 && reqn == v.gd) dif.gnt = 1'b1;
      end
      if (waiting) begin
        since++;
        if (v.k != 0 && since == v.k) begin
          dif.rvalid = 1'b1; dif.rdata = v.rdata; waiting = 0;
        end
      end
      #4;
      if (dif.req) req_seen = 1;
      if (dif.req && dif.gnt) begin
        granted = 1; waiting = v.rd; since = 0;
        g_addr = dif.addr; g_wdata = dif.wdata; g_be = dif.be; g_we = dif.we;
      end
      if (fault) begin fault_n++; cause = fault_cause; end
      if (ld_valid) begin ldv_n++; ld_pulse = load_data; end
      if (stall) stall_n++; else done = 1;
      cyc++;
    end
    check({tag, " completes"}, 32'(done), 32'd1);
    check({tag, " stall_cycles"}, 32'(stall_n), 32'(v.e_stall));
    check({tag, " fault_pulses"}, 32'(fault_n), 32'(v.e_cause != 2'b00));
    check({tag, " fault_cause"}, 32'(cause), 32'(v.e_cause));
    check({tag, " ld_valid_pulses"}, 32'(ldv_n), 32'(v.e_ldv));
    if (v.e_ldv) check({tag, " ld_data"}, ld_pulse, v.e_ld);
    check({tag, " load_data_hold"}, load_data, v.e_ld);
    exp_req = (v.e_cause == 2'b00 && (v.rd || v.wr)) || v.e_cause == 2'b11;
    check({tag, " req_seen"}, 32'(req_seen), 32'(exp_req));
    if (granted) begin
      check({tag, " be"}, 32'(g_be), 32'(v.e_be));
      check({tag, " wdata"}, g_wdata, v.e_wdata);
      check({tag, " we"}, 32'(g_we), 32'(v.wr));
      check({tag, " addr"}, g_addr, v.addr & 32'hFFFF_FFFC);
    end
    last_ld = v.e_ld;
  endtask

  vec_t tbl [16];
  vec_t rv;

  initial begin
    tbl[0]  = mkv(1, 0, 3'b010, 32'h100, 0, 1, 2, 32'hDEADBEEF, 4, 4'hF, 0, 0, 1, 32'hDEADBEEF);
    tbl[1]  = mkv(1, 0, 3'b000, 32'h103, 0, 1, 1, 32'h80123456, 3, 4'h8, 0, 0, 1, 32'hFFFFFF80);
    tbl[2]  = mkv(1, 0, 3'b100, 32'h103, 0, 2, 1, 32'h80123456, 4, 4'h8, 0, 0, 1, 32'h00000080);
    tbl[3]  = mkv(0, 1, 3'b001, 32'h102, 32'h0000ABCD, 2, 0, 0, 3, 4'hC, 32'hABCDABCD, 0, 0, 32'h80);
    tbl[4]  = mkv(1, 0, 3'b010, 32'h102, 0, 1, 1, 0, 0, 4'h0, 0, 2'b01, 0, 32'h80);
    tbl[5]  = mkv(1, 0, 3'b011, 32'h100, 0, 1, 1, 0, 0, 4'h0, 0, 2'b10, 0, 32'h80);
    tbl[6]  = mkv(1, 1, 3'b010, 32'h100, 0, 1, 1, 0, 0, 4'h0, 0, 2'b10, 0, 32'h80);
    tbl[7]  = mkv(1, 0, 3'b001, 32'h102, 0, 3, 1, 32'h80011234, 5, 4'hC, 0, 0, 1, 32'hFFFF8001);
    tbl[8]  = mkv(1, 0, 3'b101, 32'h100, 0, 1, 3, 32'h8001F234, 5, 4'h3, 0, 0, 1, 32'h0000F234);
    tbl[9]  = mkv(0, 1, 3'b000, 32'h101, 32'h123456A5, 1, 0, 0, 2, 4'h2, 32'hA5A5A5A5, 0, 0, 32'hF234);
    tbl[10] = mkv(0, 1, 3'b010, 32'h104, 32'hCAFEF00D, 1, 0, 0, 2, 4'hF, 32'hCAFEF00D, 0, 0, 32'hF234);
    tbl[11] = mkv(0, 1, 3'b001, 32'h101, 32'h1111, 1, 0, 0, 0, 4'h0, 0, 2'b01, 0, 32'hF234);
    tbl[12] = mkv(0, 1, 3'b100, 32'h100, 32'h22, 1, 0, 0, 0, 4'h0, 0, 2'b10, 0, 32'hF234);
    tbl[13] = mkv(0, 0, 3'b010, 32'h100, 0, 1, 1, 0, 0, 4'h0, 0, 2'b00, 0, 32'hF234);
    tbl[14] = mkv(1, 0, 3'b010, 32'h108, 0, 0, 0, 0, 17, 4'h0, 0, 2'b11, 0, 32'h0);
    tbl[15] = mkv(1, 0, 3'b000, 32'h102, 0, 1, 1, 32'h007F0000, 3, 4'h4, 0, 0, 1, 32'h0000007F);

    rst_n = 1'b0; mem_read = 0; mem_write = 0; funct3 = 0; alu_result = 0; store_data = 0;
    dif.gnt = 0; dif.rvalid = 0; dif.rdata = 0;
    last_ld = '0;
    #23;
    check("reset stall", 32'(stall), 0);
    check("reset ld_valid", 32'(ld_valid), 0);
    check("reset fault", 32'(fault), 0);
    check("reset fault_cause", 32'(fault_cause), 0);
    check("reset dmem_req", 32'(dif.req), 0);
    check("reset load_data", load_data, 0);
    check("reset dmem_be", 32'(dif.be), 0);
    #5 rst_n = 1'b1;

    for (int i = 0; i < 16; i++) run_op($sformatf("vec%0d", i), tbl[i]);

    for (int i = 0; i < 60; i++) begin
      int kind;
      kind     = $urandom_range(0, 15);
      rv.rd    = (kind == 1) || (kind >= 2 && kind <= 8);
      rv.wr    = (kind == 1) || (kind >= 9);
      rv.f3    = 3'($urandom_range(0, 7));
      rv.addr  = $urandom;
      rv.data  = $urandom;
      rv.gd    = $urandom_range(1, 4);
      rv.k     = $urandom_range(1, 4);
      rv.rdata = $urandom;
      rv = model(rv, last_ld);
      run_op($sformatf("rnd%0d", i), rv);
    end

    // Grant without data: timeout, then a late rvalid in IDLE must be ignored.
    rv = mkv(1, 0, 3'b010, 32'h300, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    rv = model(rv, last_ld);
    run_op("late_rvalid_op", rv);
    @(posedge clk); #1;
    mem_read = 0; dif.rvalid = 1'b1; dif.rdata = 32'h11223344;
    #4 check("late rvalid ld_valid", 32'(ld_valid), 0);
    @(posedge clk); #1;
    dif.rvalid = 1'b0;
    #4;
    check("late rvalid ld_valid next", 32'(ld_valid), 0);
    check("late rvalid load_data", load_data, 0);

    // Reset asserted while waiting in RESP.
    @(posedge clk); #1;
    mem_read = 1; mem_write = 0; funct3 = 3'b010; alu_result = 32'h200;
    @(posedge clk); #1;
    dif.gnt = 1'b1;
    @(posedge clk); #1;
    dif.gnt = 1'b0;
    #4 check("pre-reset stall in RESP", 32'(stall), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid-reset dmem_req", 32'(dif.req), 0);
    check("mid-reset stall", 32'(stall), 0);
    check("mid-reset fault", 32'(fault), 0);
    check("mid-reset ld_valid", 32'(ld_valid), 0);
    @(posedge clk);
    @(posedge clk); #3;
    mem_read = 0;
    rst_n = 1'b1;
    last_ld = '0;
    rv = mkv(1, 0, 3'b010, 32'h204, 0, 2, 1, 32'h5A5AC3C3, 0, 0, 0, 0, 0, 0);
    rv = model(rv, last_ld);
    run_op("post_reset_lw", rv);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
